gate_response_misr: RTL and testbench
=====================================

// Module: gate_response_misr
// PURPOSE
//  Downstream capture stage for the Gatter24 combinational gate models (24 in / 10 out).
//  Accepts one RESP_W-bit response word per handshake and counts accepted patterns.
//  Compacts the words into a SIG_W-bit MISR signature, which the simulator reads out
//  after a run of num_patterns vectors.
//  Sits between the gate model outputs (registered by the stimulus side) and the readout logic.
// PARAMETERS
//  RESP_W   10        response width; must satisfy RESP_W <= SIG_W
//  SIG_W    16        signature width
//  CNT_W    16        pattern counter width
//  POLY     16'h1021  MISR feedback polynomial (SIG_W bits)
//  SEED     16'h0000  signature value loaded on start
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       synchronous, active-low reset
//  start         in   1       begin run (honoured in IDLE or DONE only)
//  abort         in   1       stop run, return to IDLE
//  num_patterns  in   CNT_W   number of words to compact, sampled on start
//  resp_valid    in   1       response word valid
//  resp          in   RESP_W  gate model response word
//  resp_ready    out  1       high in RUN only
//  busy          out  1       high in RUN
//  done          out  1       high in DONE, held until start or abort
//  signature     out  SIG_W   current MISR contents
//  pattern_count out  CNT_W   words accepted in this run
// BEHAVIOUR
//  - Clocking and reset: one clock; reset is synchronous and active-low.
//  - Reset (rst_n=0 at a clk edge): state=IDLE; signature=0 (not SEED); pattern_count=0;
//    resp_ready=busy=done=0. Reset mid-run discards the run with no partial done.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE/DONE + start: signature<=SEED, pattern_count<=0, latch num_patterns.
//      Next state is RUN, or DONE directly if num_patterns==0.
//    RUN + accept (resp_valid & resp_ready): signature<=next_sig; pattern_count++.
//      Go to DONE when the accept brings pattern_count to the latched num_patterns.
//    RUN + start: ignored.
//    Any state + abort: go to IDLE with signature and pattern_count held. abort wins over start.
//  - MISR step: next_sig = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {0,resp}.
//    resp is zero-extended to SIG_W.
//  - Latency: signature and pattern_count update on the same edge as the accept (1 cycle).
//    done rises on the edge of the final accept.
//  - resp_ready depends on state only, not on resp_valid (no combinational loop).
//    Words presented outside RUN are dropped and not counted.
//  - pattern_count never wraps within a run: max num_patterns = 2^CNT_W-1.
//  - Inputs arriving while resp_valid=0 have no effect on signature.
// CONFIGURATION
//  SIG_COMPARE_EN defined: adds input expected_sig[SIG_W-1:0] and outputs pass and fail.
//    Both are sampled on entry to DONE and valid only while done=1.
//    pass = (signature==expected_sig); fail = ~pass.
//    Both are 0 in IDLE/RUN and after reset.
//  SIG_COMPARE_EN undefined: these ports and their logic are absent.
//    All other behaviour is identical.
// TESTING
//  1. Reset: hold rst_n=0 for 2 clk -> signature=0, pattern_count=0, resp_ready=busy=done=0.
//  2. Single word: start, num_patterns=1, resp=10'h001 -> signature=16'h0001 and
//     pattern_count=1; done=1 on the accept edge.
//  3. Two words, each 10'h001, resp_valid gapped by 3 idle cycles -> signature=16'h0003,
//     pattern_count=2; idle cycles leave signature unchanged.
//  4. Feedback: SEED=16'h8000, num_patterns=1, resp=0 -> signature=16'h1021.
//  5. Zero run: start with num_patterns=0 -> DONE next cycle with signature=SEED;
//     resp_ready never rises.
//  6. Mid-run events:
//     - abort after 2 of 5 words -> IDLE, pattern_count=2, done=0.
//     - rst_n=0 mid-run -> all outputs 0.
//     - SIG_COMPARE_EN with expected_sig=16'h0003 in case 3 -> pass=1, fail=0.

Source files
------------

// File: rtl/gate_response_misr.sv
// gate_response_misr: handshake capture of gate-model responses into a MISR signature.
// Optional SIG_COMPARE_EN adds expected_sig input and pass/fail verdict outputs.
module gate_response_misr #(
  parameter int               RESP_W = 10,
  parameter int               SIG_W  = 16,
  parameter int               CNT_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
`ifdef SIG_COMPARE_EN
  input  logic [SIG_W-1:0]  expected_sig,
  output logic              pass,
  output logic              fail,
`endif
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  pattern_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [SIG_W-1:0]  next_sig;
  logic [CNT_W-1:0]  cnt_inc;
  logic              take_start;
  logic              accept;

  assign take_start = start & ~abort & (state_q != S_RUN);
  assign accept     = resp_valid & ~abort & (state_q == S_RUN);
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign next_sig   = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(resp);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start)
            state_d = (num_patterns == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (accept && cnt_inc == num_q)
            state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    resp_ready = (state_q == S_RUN);
    busy       = (state_q == S_RUN);
    done       = (state_q == S_DONE);
  end

  always_comb begin
    sig_d = sig_q;
    cnt_d = cnt_q;
    num_d = num_q;
    if (take_start) begin
      sig_d = SEED;
      cnt_d = '0;
      num_d = num_patterns;
    end else if (accept) begin
      sig_d = next_sig;
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
      cnt_q <= '0;
      num_q <= '0;
    end else begin
      sig_q <= sig_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
    end
  end

  assign signature     = sig_q;
  assign pattern_count = cnt_q;

`ifdef SIG_COMPARE_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;
  logic enter_done;

  // A zero-length restart from DONE is a fresh entry and re-samples the verdict
  assign enter_done = (state_d == S_DONE) &&
                      ((state_q != S_DONE) || take_start);

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (state_d != S_DONE) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if (enter_done) begin
      pass_d = (sig_d == expected_sig);
      fail_d = (sig_d != expected_sig);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_gate_response_misr.sv
// tb_gate_response_misr: directed and randomized checks of gate_response_misr
// against a behavioural model of the capture run and MISR arithmetic.
module tb_gate_response_misr;

  localparam int          RESP_W = 10;
  localparam int          SIG_W  = 16;
  localparam int          CNT_W  = 16;
  localparam logic [15:0] POLY   = 16'h1021;
  localparam logic [15:0] SEED   = 16'h0000;
  localparam logic [15:0] SEED2  = 16'h8000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  num_patterns = '0;
  logic              resp_valid = 1'b0;
  logic [RESP_W-1:0] resp = '0;
  logic              resp_ready, busy, done;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  pattern_count;
  logic              resp_ready2, busy2, done2;
  logic [SIG_W-1:0]  signature2;
  logic [CNT_W-1:0]  pattern_count2;
`ifdef SIG_COMPARE_EN
  logic [SIG_W-1:0]  expected_sig = '0;
  logic              pass, fail, pass2, fail2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 idle, 1 run, 2 done
  int          m_st  = 0;
  logic [15:0] m_sig = '0;
  int          m_cnt = 0;
  int          m_num = 0;
  logic        m_pass = 1'b0;

  always #5 clk = ~clk;

  gate_response_misr #(
    .RESP_W(RESP_W), .SIG_W(SIG_W), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_patterns(num_patterns), .resp_valid(resp_valid), .resp(resp),
`ifdef SIG_COMPARE_EN
    .expected_sig(expected_sig), .pass(pass), .fail(fail),
`endif
    .resp_ready(resp_ready), .busy(busy), .done(done),
    .signature(signature), .pattern_count(pattern_count)
  );

  gate_response_misr #(
    .RESP_W(RESP_W), .SIG_W(SIG_W), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED2)
  ) dut_seed (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_patterns(num_patterns), .resp_valid(resp_valid), .resp(resp),
`ifdef SIG_COMPARE_EN
    .expected_sig(expected_sig), .pass(pass2), .fail(fail2),
`endif
    .resp_ready(resp_ready2), .busy(busy2), .done(done2),
    .signature(signature2), .pattern_count(pattern_count2)
  );

  // Polynomial-division step: multiply by x mod 2^16, reduce by POLY, add response
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [9:0] r);
    int v;
    v = (int'(s) * 2) % 65536;
    if (int'(s) >= 32768) v = v ^ int'(POLY);
    v = v ^ int'(r);
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int          st;
    logic [15:0] sg;
    int          cn;
    int          nm;
    logic        ps;
    st = m_st; sg = m_sig; cn = m_cnt; nm = m_num; ps = m_pass;
    if (!rst_n) begin
      st = 0; sg = '0; cn = 0; ps = 1'b0;
    end else if (abort) begin
      st = 0;
    end else if (m_st != 1) begin
      if (start) begin
        sg = SEED; cn = 0; nm = int'(num_patterns);
        st = (nm == 0) ? 2 : 1;
      end
    end else if (resp_valid) begin
      sg = misr(m_sig, resp);
      cn = m_cnt + 1;
      if (cn == m_num) st = 2;
    end
`ifdef SIG_COMPARE_EN
    if (st != 2) ps = 1'b0;
    else if (m_st != 2 || (rst_n && !abort && start)) ps = (sg == expected_sig);
`endif
    @(posedge clk);
    #1;
    m_st = st; m_sig = sg; m_cnt = cn; m_num = nm; m_pass = ps;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sig"},   32'(signature),     32'(m_sig));
    chk({tag, ".cnt"},   32'(pattern_count), 32'(m_cnt));
    chk({tag, ".busy"},  32'(busy),          32'(m_st == 1));
    chk({tag, ".ready"}, 32'(resp_ready),    32'(m_st == 1));
    chk({tag, ".done"},  32'(done),          32'(m_st == 2));
`ifdef SIG_COMPARE_EN
    chk({tag, ".pass"},  32'(pass),          32'(m_pass));
    chk({tag, ".fail"},  32'(fail),          32'(m_st == 2 && !m_pass));
`endif
  endtask

  initial begin
    int k;
    int nw;

    // Reset held for two edges
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst.sig", 32'(signature), 32'h0);
    chk("rst.cnt", 32'(pattern_count), 32'h0);
    chk("rst.flags", {29'b0, resp_ready, busy, done}, 32'h0);
    chk_all("rst");
    rst_n = 1'b1;
    cyc();

    // Single word
    start = 1'b1; num_patterns = 16'd1;
    cyc();
    start = 1'b0;
    chk_all("one.start");
    resp_valid = 1'b1; resp = 10'h001;
    cyc();
    resp_valid = 1'b0;
    chk("one.sig", 32'(signature), 32'h0001);
    chk("one.cnt", 32'(pattern_count), 32'd1);
    chk("one.done", 32'(done), 32'd1);
    chk_all("one");

    // Two words separated by idle cycles
    start = 1'b1; num_patterns = 16'd2;
`ifdef SIG_COMPARE_EN
    expected_sig = 16'h0003;
`endif
    cyc();
    start = 1'b0;
    resp_valid = 1'b1; resp = 10'h001;
    cyc();
    resp_valid = 1'b0; resp = 10'h3ff;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("gap.sig", 32'(signature), 32'h0001);
    end
    resp_valid = 1'b1; resp = 10'h001;
    cyc();
    resp_valid = 1'b0;
    chk("two.sig", 32'(signature), 32'h0003);
    chk("two.cnt", 32'(pattern_count), 32'd2);
`ifdef SIG_COMPARE_EN
    chk("two.pass", {30'b0, pass, fail}, 32'h2);
`endif
    chk_all("two");

    // Feedback through MSB on the SEED=8000 instance
    start = 1'b1; num_patterns = 16'd1;
    cyc();
    start = 1'b0;
    resp_valid = 1'b1; resp = 10'h000;
    cyc();
    resp_valid = 1'b0;
    chk("fb.sig", 32'(signature2), 32'h1021);
    chk_all("fb");

    // Zero-length run goes straight to DONE holding SEED
    start = 1'b1; num_patterns = 16'd0;
    cyc();
    start = 1'b0;
    chk("zero.done", 32'(done), 32'd1);
    chk("zero.seed", 32'(signature2), 32'(SEED2));
    chk_all("zero");
    resp_valid = 1'b1; resp = 10'h155;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("zero.ready", 32'(resp_ready), 32'd0);
    end
    resp_valid = 1'b0;
    chk_all("zero.hold");

    // Abort after 2 of 5 words, then dropped words in IDLE
    start = 1'b1; num_patterns = 16'd5;
    cyc();
    start = 1'b0;
    resp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      resp = 10'($urandom);
      cyc();
    end
    resp_valid = 1'b0; abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk("abort.cnt", 32'(pattern_count), 32'd2);
    chk("abort.done", 32'(done), 32'd0);
    chk_all("abort");
    resp_valid = 1'b1; resp = 10'h2aa;
    cyc();
    resp_valid = 1'b0;
    chk_all("abort.drop");

    // Reset mid-run
    start = 1'b1; num_patterns = 16'd5;
    cyc();
    start = 1'b0;
    resp_valid = 1'b1; resp = 10'h3c3;
    cyc();
    resp_valid = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mrst.all", {signature, pattern_count}, 32'h0);
    chk("mrst.flags", {29'b0, resp_ready, busy, done}, 32'h0);
    chk_all("mrst");

    // Randomized runs with stray starts and bursty valid
    for (int r = 0; r < 25; r++) begin
      nw = int'($urandom_range(10, 1));
      start = 1'b1; num_patterns = 16'(nw);
`ifdef SIG_COMPARE_EN
      expected_sig = 16'($urandom);
`endif
      cyc();
      start = 1'b0;
      chk_all("rnd.start");
      k = 0;
      while (m_st == 1 && k < 80) begin
        resp_valid = (k > 40) ? 1'b1 : 1'($urandom);
        resp = 10'($urandom);
        start = (($urandom % 6) == 0);
`ifdef SIG_COMPARE_EN
        if (r % 2 == 0) expected_sig = misr(m_sig, resp);
`endif
        cyc();
        chk_all("rnd.step");
        k++;
      end
      start = 1'b0; resp_valid = 1'b0;
      chk("rnd.finish", 32'(done), 32'd1);
      resp_valid = 1'b1; resp = 10'($urandom);
      cyc();
      resp_valid = 1'b0;
      chk_all("rnd.held");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
